// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode handshake bundle: fetch-side beat in, decode-side beat out.
// The pipeline register uses the slave view; the fetch/decode environment uses master.
interface if_id_pipe_reg_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int INSTR_WIDTH   = 32
);
   logic                     validF;
   logic                     readyF;
   logic [INSTR_WIDTH-1:0]   instrF;
   logic [ADDRESS_WIDTH-1:0] pcF;
   logic [ADDRESS_WIDTH-1:0] PCPlus4F;
   logic                     flushD;
   logic                     readyD;
   logic                     validD;
   logic [INSTR_WIDTH-1:0]   instrD;
   logic [ADDRESS_WIDTH-1:0] pcD;
   logic [ADDRESS_WIDTH-1:0] PCPlus4D;

   modport master (
      output validF, instrF, pcF, PCPlus4F, flushD, readyD,
      input  readyF, validD, instrD, pcD, PCPlus4D
   );

   modport slave (
      input  validF, instrF, pcF, PCPlus4F, flushD, readyD,
      output readyF, validD, instrD, pcD, PCPlus4D
   );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, decode stall,
// synchronous redirect flush and NOP bubbles. With SKID_EN=1 a second
// (skid) entry absorbs the beat offered while decode stalls, so readyF
// depends only on registered state.
module if_id_pipe_reg #(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter int                     INSTR_WIDTH   = 32,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR     = INSTR_WIDTH'(32'h0000_0013),
   parameter bit                     SKID_EN       = 1'b1
) (
   input logic             clk,
   input logic             rst,
   if_id_pipe_reg_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t                   state_q;
   state_t                   state_n;
   logic                     ready_f;
   logic                     vld_p1;
   logic                     accept;
   logic                     drain;
   logic                     ld_main_f;
   logic                     ld_main_skid;
   logic                     ld_skid;
   logic                     bubble;

   logic [INSTR_WIDTH-1:0]   instr_p1;
   logic [ADDRESS_WIDTH-1:0] pc_p1;
   logic [ADDRESS_WIDTH-1:0] pcp4_p1;
   logic [INSTR_WIDTH-1:0]   skid_instr_p1;
   logic [ADDRESS_WIDTH-1:0] skid_pc_p1;
   logic [ADDRESS_WIDTH-1:0] skid_pcp4_p1;

   assign accept = bus.validF & ready_f;
   assign drain  = vld_p1 & bus.readyD;

   // State register: the main entry is valid in FULL and SKID, skid only in SKID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_n;
      end
   end

   // Next state: flush wins over everything, including a same-cycle accept.
   always_comb begin
      state_n = state_q;
      if (bus.flushD) begin
         state_n = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) state_n = ST_FULL;
            ST_FULL: begin
               if (drain) begin
                  if (!accept) state_n = ST_EMPTY;
               end else if (accept && SKID_EN) begin
                  state_n = ST_SKID;
               end
            end
            ST_SKID:  if (drain) state_n = ST_FULL;
            default:  state_n = ST_EMPTY;
         endcase
      end
   end

   // Outputs: registered readyF with a skid entry, pass-through of readyD without one.
   always_comb begin
      vld_p1 = (state_q != ST_EMPTY);
      if (SKID_EN) begin
         ready_f = (state_q != ST_SKID);
      end else begin
         ready_f = bus.readyD | ~vld_p1;
      end
   end

   // Datapath load strobes derived from state and handshake.
   always_comb begin
      ld_main_f    = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      bubble       = 1'b0;
      if (!bus.flushD) begin
         case (state_q)
            ST_EMPTY: ld_main_f = accept;
            ST_FULL: begin
               if (drain) begin
                  ld_main_f = accept;
                  bubble    = ~accept;
               end else begin
                  ld_skid = accept & SKID_EN;
               end
            end
            ST_SKID:  ld_main_skid = drain;
            default:  ;
         endcase
      end
   end

   // ---- stage p1: main entry (drives the decode outputs directly) ----
   // Main entry: flush and bubbles only replace the instruction; PCs keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_p1 <= NOP_INSTR;
         pc_p1    <= '0;
         pcp4_p1  <= '0;
      end else if (bus.flushD) begin
         instr_p1 <= NOP_INSTR;
      end else if (ld_main_skid) begin
         instr_p1 <= skid_instr_p1;
         pc_p1    <= skid_pc_p1;
         pcp4_p1  <= skid_pcp4_p1;
      end else if (ld_main_f) begin
         instr_p1 <= bus.instrF;
         pc_p1    <= bus.pcF;
         pcp4_p1  <= bus.PCPlus4F;
      end else if (bubble) begin
         instr_p1 <= NOP_INSTR;
      end
   end

   // Skid entry: captures the beat accepted while decode stalls a full main entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_instr_p1 <= NOP_INSTR;
         skid_pc_p1    <= '0;
         skid_pcp4_p1  <= '0;
      end else if (ld_skid) begin
         skid_instr_p1 <= bus.instrF;
         skid_pc_p1    <= bus.pcF;
         skid_pcp4_p1  <= bus.PCPlus4F;
      end
   end

   assign bus.readyF   = ready_f;
   assign bus.validD   = vld_p1;
   assign bus.instrD   = instr_p1;
   assign bus.pcD      = pc_p1;
   assign bus.PCPlus4D = pcp4_p1;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid-enabled 32-bit instance and a
// skid-less 16-bit instance driven by directed beats, with a
// queue-based scoreboard checked by per-instance monitors.
module tb_if_id_pipe_reg;

   logic clk;
   logic rst;

   if_id_pipe_reg_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) ifa ();
   if_id_pipe_reg_if #(.ADDRESS_WIDTH(16), .INSTR_WIDTH(16)) ifb ();

   if_id_pipe_reg #(
      .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(32'h0000_0013), .SKID_EN(1'b1)
   ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

   if_id_pipe_reg #(
      .ADDRESS_WIDTH(16), .INSTR_WIDTH(16), .NOP_INSTR(16'h0013), .SKID_EN(1'b0)
   ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcp4;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];
   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus on instance a (b=0) or b (b=1); the expected beat
   // is queued when the handshake completes, and a flush discards the queue.
   task automatic step(input bit b, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] p4,
                       input bit rdy, input bit fl);
      @(posedge clk);
      #1;
      if (!b) begin
         ifa.validF = v; ifa.instrF = ins; ifa.pcF = pc; ifa.PCPlus4F = p4;
         ifa.readyD = rdy; ifa.flushD = fl;
      end else begin
         ifb.validF = v; ifb.instrF = ins[15:0]; ifb.pcF = pc[15:0];
         ifb.PCPlus4F = p4[15:0]; ifb.readyD = rdy;
      end
      @(negedge clk);
      if (!b) begin
         if (fl) qa.delete();
         else if (v && ifa.readyF) qa.push_back(beat_t'{ins, pc, p4});
      end else begin
         if (v && ifb.readyF) qb.push_back(beat_t'{ins, pc, p4});
      end
   endtask

   // Monitor a: every beat consumed by decode must be the next expected one.
   always @(negedge clk) begin
      if (!rst && ifa.validD && ifa.readyD) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_beat: got pc %h, expected no beat", ifa.pcD);
         end else begin
            beat_t e;
            e = qa.pop_front();
            chk("a_pcD", ifa.pcD, e.pc);
            chk("a_instrD", ifa.instrD, e.instr);
            chk("a_PCPlus4D", ifa.PCPlus4D, e.pcp4);
         end
      end
   end

   // Monitor b: same for the narrow skid-less instance.
   always @(negedge clk) begin
      if (!rst && ifb.validD && ifb.readyD) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_beat: got pc %h, expected no beat", ifb.pcD);
         end else begin
            beat_t e;
            e = qb.pop_front();
            chk("b_pcD", 32'(ifb.pcD), e.pc);
            chk("b_instrD", 32'(ifb.instrD), e.instr);
            chk("b_PCPlus4D", 32'(ifb.PCPlus4D), e.pcp4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      ifa.validF = 1'b0; ifa.instrF = '0; ifa.pcF = '0; ifa.PCPlus4F = '0;
      ifa.readyD = 1'b1; ifa.flushD = 1'b0;
      ifb.validF = 1'b0; ifb.instrF = '0; ifb.pcF = '0; ifb.PCPlus4F = '0;
      ifb.readyD = 1'b1; ifb.flushD = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_validD", 32'(ifa.validD), 32'd0);
      chk("rst_instrD", ifa.instrD, 32'h0000_0013);
      chk("rst_pcD", ifa.pcD, 32'd0);
      chk("rst_PCPlus4D", ifa.PCPlus4D, 32'd0);
      chk("rst_readyF", 32'(ifa.readyF), 32'd1);
      chk("rst_b_instrD", 32'(ifb.instrD), 32'h0013);
      @(posedge clk);
      #1 rst = 1'b0;

      // Streaming: one-cycle latency, back-to-back beats
      step(0, 1, 32'h0050_0093, 32'h0, 32'h4, 1, 0);
      chk("stream_latency_validD", 32'(ifa.validD), 32'd0);
      step(0, 1, 32'h00A0_0113, 32'h4, 32'h8, 1, 0);
      chk("stream_first_validD", 32'(ifa.validD), 32'd1);
      step(0, 1, 32'h0020_81B3, 32'h8, 32'hC, 1, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("bubble_validD", 32'(ifa.validD), 32'd0);
      chk("bubble_instrD", ifa.instrD, 32'h0000_0013);

      // Stall with skid
      step(0, 1, 32'h1111_0013, 32'h10, 32'h14, 1, 0);
      step(0, 1, 32'h2222_0013, 32'h14, 32'h18, 0, 0);
      chk("stall_pcD_full", ifa.pcD, 32'h10);
      step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("skid_readyF", 32'(ifa.readyF), 32'd0);
      chk("skid_pcD_hold", ifa.pcD, 32'h10);
      step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("skid_instrD_hold", ifa.instrD, 32'h1111_0013);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("skid_drain_readyF", 32'(ifa.readyF), 32'd0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("skid_after_readyF", 32'(ifa.readyF), 32'd1);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("skid_empty_validD", 32'(ifa.validD), 32'd0);

      // Flush while in SKID with an incoming beat
      step(0, 1, 32'h3333_0013, 32'h30, 32'h34, 1, 0);
      step(0, 1, 32'h3434_0013, 32'h34, 32'h38, 0, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("flush_pre_readyF", 32'(ifa.readyF), 32'd0);
      step(0, 1, 32'h2020_0013, 32'h20, 32'h24, 0, 1);
      step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("flush_validD", 32'(ifa.validD), 32'd0);
      chk("flush_instrD", ifa.instrD, 32'h0000_0013);
      chk("flush_readyF", 32'(ifa.readyF), 32'd1);
      chk("flush_pcD_kept", ifa.pcD, 32'h30);

      // Flush in FULL discards a same-cycle accepted beat
      step(0, 1, 32'h4040_0013, 32'h40, 32'h44, 0, 0);
      step(0, 1, 32'h4444_0013, 32'h44, 32'h48, 0, 1);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("flush_full_validD", 32'(ifa.validD), 32'd0);
      chk("flush_full_pcD_kept", ifa.pcD, 32'h40);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("flush_full_validD2", 32'(ifa.validD), 32'd0);

      // Async reset in the middle of a skid stall
      step(0, 1, 32'h5050_0013, 32'h50, 32'h54, 1, 0);
      step(0, 1, 32'h5454_0013, 32'h54, 32'h58, 0, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("arst_pre_readyF", 32'(ifa.readyF), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_validD", 32'(ifa.validD), 32'd0);
      chk("arst_readyF", 32'(ifa.readyF), 32'd1);
      chk("arst_instrD", ifa.instrD, 32'h0000_0013);
      chk("arst_pcD", ifa.pcD, 32'd0);
      qa.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      step(0, 1, 32'h6060_0013, 32'h60, 32'h64, 1, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);

      // Skid-less narrow instance: combinational readyF
      step(1, 1, 32'h0093, 32'h0100, 32'h0104, 1, 0);
      step(1, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("b_stall_readyF", 32'(ifb.readyF), 32'd0);
      chk("b_stall_pcD", 32'(ifb.pcD), 32'h0100);
      step(1, 1, 32'h0113, 32'h0104, 32'h0108, 0, 0);
      chk("b_hold_pcD", 32'(ifb.pcD), 32'h0100);
      chk("b_hold_instrD", 32'(ifb.instrD), 32'h0093);
      step(1, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("b_release_readyF", 32'(ifb.readyF), 32'd1);
      step(1, 1, 32'h0113, 32'h0104, 32'h0108, 1, 0);
      step(1, 1, 32'h01B3, 32'h0108, 32'h010C, 1, 0);
      step(1, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      step(1, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      chk("b_bubble_validD", 32'(ifb.validD), 32'd0);
      chk("b_bubble_instrD", 32'(ifb.instrD), 32'h0013);

      chk("a_queue_empty", 32'(qa.size()), 32'd0);
      chk("b_queue_empty", 32'(qb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Next-generation fetch-to-decode pipeline register for the pipelined RV32 core. It replaces the free-running IF/ID flop stage with a valid/ready handshaked stage. The stage supports decode back-pressure (stall), a synchronous flush for branch/jump redirects, and NOP bubble insertion. An optional skid entry keeps the upstream-ready path registered. It sits between the instruction memory/PC logic and the decode stage.

Parameters:
ADDRESS_WIDTH, 32, width of pcF/pcD and PCPlus4F/PCPlus4D.
INSTR_WIDTH, 32, width of instrF/instrD.
NOP_INSTR, 32'h0000_0013, value driven on instrD whenever validD=0 (addi x0,x0,0).
SKID_EN, 1, 1 = two-entry (main + skid) with registered readyF; 0 = single entry with combinational readyF.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
validF  input  1  fetch presents a valid beat.
readyF  output  1  stage can accept a beat this cycle.
instrF  input  INSTR_WIDTH  fetched instruction.
pcF  input  ADDRESS_WIDTH  PC of fetched instruction.
PCPlus4F  input  ADDRESS_WIDTH  pcF+4 from fetch.
flushD  input  1  synchronous flush (redirect); kills all held and incoming beats.
readyD  input  1  decode can consume; 0 = stall.
validD  output  1  instrD/pcD/PCPlus4D hold a valid beat.
instrD  output  INSTR_WIDTH  registered instruction; NOP_INSTR when validD=0.
pcD  output  ADDRESS_WIDTH  registered PC.
PCPlus4D  output  ADDRESS_WIDTH  registered PC+4.

Behaviour:
- Reset (async, immediate, mid-operation too): validD=0, instrD=NOP_INSTR, pcD=0, PCPlus4D=0, skid entry empty, state EMPTY, readyF=1.
- accept = validF & readyF; drain = validD & readyD.
- Latency: an accepted beat appears on the D outputs at the next posedge when the main register is free or draining (1 cycle).
- States (SKID_EN=1):
  - EMPTY: readyF=1. On accept, load main and go to FULL; otherwise hold.
  - FULL: readyF=1.
    - readyD & accept: load main, stay FULL.
    - readyD & !accept: go to EMPTY, instrD<=NOP_INSTR.
    - !readyD & accept: capture the beat into skid, go to SKID.
    - !readyD & !accept: hold.
  - SKID: readyF=0.
    - readyD: main<=skid, skid empty, go to FULL.
    - else hold.
- readyF is a pure function of the registered state when SKID_EN=1 (no combinational path from readyD).
- SKID_EN=0: readyF = readyD | ~validD (combinational). SKID is unreachable, and !readyD with validD=1 holds the outputs.
- Flush (highest priority, synchronous): at the edge, validD<=0, instrD<=NOP_INSTR, skid emptied, state EMPTY. Any beat accepted in the same cycle is discarded. pcD/PCPlus4D keep their prior values. readyF=1 the following cycle.
- Stall: while validD=1 & readyD=0, instrD/pcD/PCPlus4D are stable, with no glitch or reload.
- Beats are delivered in order with no duplication and no loss except on flush.
- Only the width of the data paths changes with the parameters; the datapath performs no arithmetic.

Test Plan:
- Reset then stream: rst pulse; validF=1, readyD=1 with pc=0x0,0x4,0x8 (instr 0x00500093, ...) -> validD rises 1 cycle later; pcD=0x0,0x4,0x8 on consecutive cycles; PCPlus4D=pc+4.
- Stall with skid: full with pc=0x10, readyD=0, pc=0x14 offered -> 0x14 accepted into skid; readyF=0 next cycle; pcD holds 0x10. readyD=1 -> pcD=0x10 then 0x14, no loss or duplicate, readyF back to 1.
- Flush in SKID state plus incoming beat: flushD=1 with validF=1 pc=0x20 -> next cycle validD=0, instrD=0x00000013, readyF=1. 0x20 and the skid beat never appear on pcD with validD=1.
- Drain to bubble: FULL with readyD=1 and validF=0 -> validD=0, instrD=NOP_INSTR next cycle.
- Async reset mid-stall: assert rst between edges while in SKID -> validD=0 and readyF=1 immediately, without waiting for a clock edge.
- SKID_EN=0, INSTR_WIDTH=16, ADDRESS_WIDTH=16: readyD=0 while validD=1 -> readyF=0 in the same cycle, outputs held. readyD=1 -> readyF=1 combinationally.
